// File: rtl/mem_pkg.sv
`timescale 1ns/1ps
// mem_pkg: constants and types shared between the memory responder and the
// CPU-side controller that issues commands to it.
//   MNONE/MREAD/MWRITE  : mem_cmd encodings (2'b11 is illegal)
//   LED_ADDR / SW_ADDR  : memory-mapped LED register and switch inputs
//   state_e             : responder FSM states
//   region_e            : address decode result
package mem_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_LED  = 2'd1,
    RGN_SW   = 2'd2,
    RGN_NONE = 2'd3
  } region_e;

  // Lower half of the 9-bit space is RAM; the upper half holds only the
  // two peripheral addresses, everything else there is unmapped.
  function automatic region_e decode_addr(input logic [8:0] addr);
    if (!addr[8])              return RGN_RAM;
    else if (addr == LED_ADDR) return RGN_LED;
    else if (addr == SW_ADDR)  return RGN_SW;
    else                       return RGN_NONE;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
`timescale 1ns/1ps
// mem_responder_if: command/response bus between a CPU-side master and the
// memory responder.
//   mem_cmd    : MNONE / MREAD / MWRITE (master -> slave)
//   mem_addr   : 9-bit word address      (master -> slave)
//   write_data : data for MWRITE          (master -> slave)
//   read_data  : data of completed MREAD  (slave -> master)
//   mem_ready  : one-cycle completion pulse (slave -> master)
//   mem_err    : unmapped-access flag, pulses with mem_ready (slave -> master)
interface mem_responder_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, mem_ready, mem_err
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, mem_ready, mem_err
  );
endinterface

// File: rtl/ram_sp.sv
`timescale 1ns/1ps
// ram_sp: single-port 16-bit RAM, synchronous write and registered
// read-first output. Contents have no reset.
//   clk     : clock
//   i_we    : write enable
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : registered read data (value before any same-edge write)
module ram_sp #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdata,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// mem_responder: answers MREAD/MWRITE commands on a 9-bit word address space
// holding RAM, an LED register and the switch inputs, with a configurable
// number of wait cycles before the one-cycle mem_ready pulse.
//   clk      : clock, rising edge
//   reset    : asynchronous reset, active low
//   bus      : command/response bus (slave side)
//   switches : external switch inputs, readable at SW_ADDR
//   leds     : LED register, read/write at LED_ADDR
//
// state | meaning
// IDLE  | waiting; captures a MREAD/MWRITE on the next rising edge
// BUSY  | counting down the wait cycles on the captured command
// DONE  | mem_ready (and mem_err if unmapped) high for this one cycle
module mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int RAM_WORDS   = 256
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus,
  input  logic [7:0]     switches,
  output logic [7:0]     leds
);

  localparam int         AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_e      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_cmd;
  logic [8:0]  r_addr;
  logic [15:0] r_wdata;
  logic        r_ready;
  logic        r_err;
  logic [7:0]  r_leds;
  logic [15:0] r_read_data;
  logic        r_rd_ram;

  logic        w_idle;
  logic        w_start;
  logic        w_go_done;
  logic [1:0]  w_cmd;
  logic [8:0]  w_addr;
  logic [15:0] w_wdata;
  region_e     w_rgn;
  logic        w_ram_we;
  logic [15:0] w_ram_q;

  assign w_idle  = (r_state == IDLE);
  assign w_start = w_idle && ((bus.mem_cmd == MREAD) || (bus.mem_cmd == MWRITE));

  // In IDLE the live bus is used so a zero-wait transaction can complete on
  // its capture edge; afterwards only the captured copy is looked at.
  assign w_cmd   = w_idle ? bus.mem_cmd    : r_cmd;
  assign w_addr  = w_idle ? bus.mem_addr   : r_addr;
  assign w_wdata = w_idle ? bus.write_data : r_wdata;
  assign w_rgn   = decode_addr(w_addr);

  // The edge entering DONE: every side effect of a transaction happens here.
  assign w_go_done = (w_start && NO_WAIT) || ((r_state == BUSY) && (r_cnt == 3'd0));

  // RAM is not reset, so its write enable is masked while reset is held.
  assign w_ram_we = reset && w_go_done && (w_cmd == MWRITE) && (w_rgn == RGN_RAM);

  // The RAM reads its address every cycle, so its registered output holds
  // the addressed word from the DONE edge onwards.
  ram_sp #(
    .DEPTH (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_addr[AW-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_cmd       <= MNONE;
      r_addr      <= 9'd0;
      r_wdata     <= 16'd0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_leds      <= 8'd0;
      r_read_data <= 16'd0;
      r_rd_ram    <= 1'b0;
    end else begin
      r_ready <= w_go_done;
      r_err   <= w_go_done && (w_rgn == RGN_NONE);

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cmd   <= bus.mem_cmd;
            r_addr  <= bus.mem_addr;
            r_wdata <= bus.write_data;
            if (NO_WAIT) begin
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        BUSY: begin
          if (r_cnt == 3'd0) r_state <= DONE;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_go_done) begin
        if ((w_cmd == MWRITE) && (w_rgn == RGN_LED)) r_leds <= w_wdata[7:0];
        if (w_cmd == MREAD) begin
          // RAM data only lands in the RAM output register on this edge, so
          // it is passed through during DONE and copied on the way out.
          r_rd_ram <= (w_rgn == RGN_RAM);
          case (w_rgn)
            RGN_LED: r_read_data <= {8'h00, r_leds};
            RGN_SW:  r_read_data <= {8'h00, switches};
            RGN_RAM: r_read_data <= r_read_data;
            default: r_read_data <= 16'h0000;
          endcase
        end
      end else if (r_rd_ram) begin
        r_read_data <= w_ram_q;
        r_rd_ram    <= 1'b0;
      end
    end
  end

  assign bus.read_data = r_rd_ram ? w_ram_q : r_read_data;
  assign bus.mem_ready = r_ready;
  assign bus.mem_err   = r_err;
  assign leds          = r_leds;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra cycles between request capture and the mem_ready pulse (legal range 0..7).
REQ-002 SHALL have parameter RAM_WORDS, default 256, meaning number of 16-bit RAM words (power of two, at most 256).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port mem_cmd, input, 2 bits: 00 MNONE, 01 MREAD, 10 MWRITE, 11 illegal.
REQ-006 SHALL have port mem_addr, input, 9 bits: word address.
REQ-007 SHALL have port write_data, input, 16 bits: data for MWRITE.
REQ-008 SHALL have port switches, input, 8 bits: external switch inputs.
REQ-009 SHALL have port read_data, output, 16 bits: data for the completed MREAD.
REQ-010 SHALL have port mem_ready, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port mem_err, output, 1 bit: pulses with mem_ready for an unmapped access.
REQ-012 SHALL have port leds, output, 8 bits: LED register.

Function
REQ-013 SHALL use the FSM states IDLE, BUSY and DONE.
REQ-014 In IDLE, SHALL capture mem_cmd, mem_addr and write_data on a rising edge when mem_cmd is 01 or 10; the FSM then goes to BUSY, or to DONE directly if WAIT_CYCLES is 0.
REQ-015 In IDLE, mem_cmd 00 or 11 SHALL start no transaction; 11 SHALL have no side effect.
REQ-016 BUSY SHALL count WAIT_CYCLES cycles with a 3-bit counter, then go to DONE.
REQ-017 Inputs that change during BUSY or DONE SHALL be ignored; only the captured values are used.
REQ-018 mem_ready SHALL be 1 only in DONE, so it pulses in cycle k+1+WAIT_CYCLES for a capture edge at cycle k.
REQ-019 DONE SHALL always go to IDLE, so the minimum spacing between transactions is 2+WAIT_CYCLES cycles.
REQ-020 A command held into IDLE after DONE SHALL start a new transaction.
REQ-021 Address decode:
- addr[8]=0 maps to RAM word addr[7:0] mod RAM_WORDS.
- 0x100 maps to the LED register: read returns {8'h00, leds}; write loads write_data[7:0].
- 0x140 maps to the switches: read returns {8'h00, switches}; write is ignored with no error.
- Any other address is unmapped: read returns 0, write is ignored, mem_err pulses with mem_ready.
REQ-022 A write SHALL take effect on the edge entering DONE, never earlier.
REQ-023 read_data SHALL be valid while mem_ready is 1 and held until the next MREAD completes; writes SHALL not change it.
REQ-024 A read of a RAM word written by the immediately preceding transaction SHALL return the new value.

Reset
REQ-025 Asserting reset (0) SHALL asynchronously force: state IDLE, counter 0, read_data 0, mem_ready 0, mem_err 0, leds 0.
REQ-026 Reset asserted during BUSY SHALL abort the transaction: no RAM or LED write, no mem_ready.
REQ-027 RAM contents SHALL NOT be affected by reset.
REQ-028 The first capture SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-029 Shared package mem_pkg SHALL hold:
- the MNONE/MREAD/MWRITE constants (shared with the CPU controller);
- the LED_ADDR (0x100) and SW_ADDR (0x140) constants;
- the FSM state enum.
REQ-030 SHALL instantiate one sub-module, ram_sp (parameterised depth, 16-bit, single-port, synchronous write and read); the read SHALL be issued so data is registered by DONE.

Verification
REQ-031 WAIT_CYCLES=1: MWRITE 0x005 with 0xBEEF, then MREAD 0x005 -> each mem_ready pulses exactly 2 cycles after its capture edge; read_data=0xBEEF, mem_err=0.
REQ-032 WAIT_CYCLES=0: MWRITE 0x100 with 0x12A5 -> leds=0xA5 from the DONE edge; then MREAD 0x100 -> read_data=0x00A5.
REQ-033 switches=0x3C, MREAD 0x140 -> read_data=0x003C; then MWRITE 0x140 -> leds unchanged, mem_err=0.
REQ-034 MREAD 0x1FF -> read_data=0x0000 with mem_err=1 for one cycle; MWRITE 0x180 -> no RAM or LED change, mem_err=1.
REQ-035 WAIT_CYCLES=3: MWRITE 0x010 with 0x1111, reset pulsed low during BUSY -> no mem_ready; a later MREAD 0x010 returns the prior contents; leds=0.
REQ-036 MREAD held high for 10 cycles with WAIT_CYCLES=1 -> mem_ready pulses every 3 cycles; changing mem_addr during BUSY does not alter read_data; mem_cmd=11 -> no mem_ready.
